d2d_flit_packer: RTL and testbench

D2D_FLIT_PACKER -- requirements
Module: d2d_flit_packer

---
 rtl/d2d_flit_packer.sv | 132 +++++++++++++
 tb/tb_d2d_flit_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/d2d_flit_packer.sv
// d2d_flit_packer: serialises a 16-bit address / 32-bit data transaction into
// four 16-bit flits (HDR, DATA hi, DATA lo, CHK) for a die-to-die link.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction held, ready to accept
// HDR   | presenting header flit (captured address)
// DHI   | presenting upper data half
// DLO   | presenting lower data half
// CHK   | presenting checksum flit, last of the transaction; can accept next
module d2d_flit_packer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inData,
  input  logic [15:0]      inAddr,
  input  logic             inValid,
  output logic             inReady,
  output logic [15:0]      flitData,
  output logic [1:0]       flitKind,
  output logic             flitLast,
  output logic             flitValid,
  input  logic             flitReady,
  output logic [CNT_W-1:0] txCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [1:0] KIND_HDR  = 2'd0;
  localparam logic [1:0] KIND_DATA = 2'd1;
  localparam logic [1:0] KIND_CHK  = 2'd2;

  state_t           state_q, state_d;
  logic [15:0]      addr_q;
  logic [31:0]      data_q;
  logic [15:0]      chk_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_hs;
  logic             chk_hs;

  // Ready is held low during reset so nothing is accepted while the block is cleared.
  always_comb begin
    inReady = reset && ((state_q == S_IDLE) || ((state_q == S_CHK) && flitReady));
    in_hs   = inValid && inReady;
    chk_hs  = (state_q == S_CHK) && flitReady;
  end

  // Next-state logic; the CHK handshake can chain straight into the next HDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (inValid)   state_d = S_HDR;
      S_HDR:   if (flitReady) state_d = S_DHI;
      S_DHI:   if (flitReady) state_d = S_DLO;
      S_DLO:   if (flitReady) state_d = S_CHK;
      S_CHK:   if (flitReady) state_d = inValid ? S_HDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flit outputs depend only on state and captured registers, never on live inputs.
  always_comb begin
    flitValid = 1'b0;
    flitData  = 16'h0000;
    flitKind  = KIND_HDR;
    flitLast  = 1'b0;
    case (state_q)
      S_HDR: begin
        flitValid = 1'b1;
        flitData  = addr_q;
        flitKind  = KIND_HDR;
      end
      S_DHI: begin
        flitValid = 1'b1;
        flitData  = data_q[31:16];
        flitKind  = KIND_DATA;
      end
      S_DLO: begin
        flitValid = 1'b1;
        flitData  = data_q[15:0];
        flitKind  = KIND_DATA;
      end
      S_CHK: begin
        flitValid = 1'b1;
        flitData  = chk_q;
        flitKind  = KIND_CHK;
        flitLast  = 1'b1;
      end
      default: ;
    endcase
  end

  // Completed-transaction counter wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (chk_hs) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State and counter registers; reset discards any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture payload and precompute checksum only on an input handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= 16'h0000;
      data_q <= 32'h0000_0000;
      chk_q  <= 16'h0000;
    end else if (in_hs) begin
      addr_q <= inAddr;
      data_q <= inData;
      chk_q  <= inAddr ^ inData[31:16] ^ inData[15:0];
    end
  end

  assign txCount = cnt_q;

endmodule

// File: tb/tb_d2d_flit_packer.sv
// Testbench for d2d_flit_packer: scoreboard of expected flits fed from accepted
// transactions, independent monitor comparing every emitted flit.
module tb_d2d_flit_packer;

  logic        clock;
  logic        reset;
  logic [31:0] inData;
  logic [15:0] inAddr;
  logic        inValid;
  logic        inReady;
  logic [15:0] flitData;
  logic [1:0]  flitKind;
  logic        flitLast;
  logic        flitValid;
  logic        flitReady;
  logic [7:0]  txCount;

  d2d_flit_packer #(.CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .inData    (inData),
    .inAddr    (inAddr),
    .inValid   (inValid),
    .inReady   (inReady),
    .flitData  (flitData),
    .flitKind  (flitKind),
    .flitLast  (flitLast),
    .flitValid (flitValid),
    .flitReady (flitReady),
    .txCount   (txCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Expected flit = {last, kind, data}
  logic [18:0] exp_q[$];
  logic [7:0]  exp_cnt = 8'd0;
  logic        hold_v = 1'b0;
  logic [18:0] hold_flit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted transaction becomes four flits.
  always @(negedge clock) begin
    if (reset && inValid && inReady) begin
      exp_q.push_back({1'b0, 2'd0, inAddr});
      exp_q.push_back({1'b0, 2'd1, inData[31:16]});
      exp_q.push_back({1'b0, 2'd1, inData[15:0]});
      exp_q.push_back({1'b1, 2'd2, inAddr ^ inData[31:16] ^ inData[15:0]});
    end
  end

  // Monitor: pops on every output handshake, checks stall stability and counter.
  always @(negedge clock) begin
    logic [18:0] cur;
    logic [18:0] e;
    cur = {flitLast, flitKind, flitData};
    if (!reset) begin
      exp_q.delete();
      exp_cnt = 8'd0;
      hold_v  = 1'b0;
    end else begin
      chk("txCount", {24'd0, txCount}, {24'd0, exp_cnt});
      if (hold_v) begin
        chk("stall_valid", {31'd0, flitValid}, 32'd1);
        chk("stall_flit", {13'd0, cur}, {13'd0, hold_flit});
      end
      if (flitValid && flitReady) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", {13'd0, cur}, 32'h7ffff);
        end else begin
          e = exp_q.pop_front();
          chk("flit", {13'd0, cur}, {13'd0, e});
          if (e[17:16] == 2'd2) exp_cnt = exp_cnt + 8'd1;
        end
      end else if (flitValid) begin
        hold_v    = 1'b1;
        hold_flit = cur;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    int iter;
    logic go;
    reset     = 1'b0;
    inValid   = 1'b0;
    inData    = 32'h0;
    inAddr    = 16'h0;
    flitReady = 1'b0;
    #12;
    chk("rst_flitValid", {31'd0, flitValid}, 32'd0);
    chk("rst_inReady", {31'd0, inReady}, 32'd0);
    chk("rst_txCount", {24'd0, txCount}, 32'd0);
    chk("rst_flit", {13'd0, flitLast, flitKind, flitData}, 32'd0);
    tick();
    reset = 1'b1;

    // Idle
    flitReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", {31'd0, flitValid}, 32'd0);
      chk("idle_ready", {31'd0, inReady}, 32'd1);
    end

    // Basic transfer
    inAddr = 16'h0001; inData = 32'hA5A5A5A5; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("basic_hdr_latency", {31'd0, flitValid}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("basic_count", {24'd0, txCount}, 32'd1);

    // Back-to-back
    inAddr = 16'h1234; inData = 32'hDEADBEEF; inValid = 1'b1;
    tick();
    inAddr = 16'h0001; inData = 32'hA5A5A5A5;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", {31'd0, flitValid}, 32'd1);
      if (i == 3) begin
        chk("b2b_chk", {16'd0, flitData}, 32'h7276);
        chk("b2b_inReady", {31'd0, inReady}, 32'd1);
      end
      tick();
      if (i == 3) inValid = 1'b0;
    end
    chk("b2b_idle", {31'd0, flitValid}, 32'd0);
    chk("b2b_count", {24'd0, txCount}, 32'd3);

    // Backpressure during DHI with upstream data churn
    inAddr = 16'h1111; inData = 32'hDEAD0000; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    flitReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inData = $urandom;
      inAddr = 16'($urandom);
      tick();
      chk("bp_data", {16'd0, flitData}, 32'hDEAD);
      chk("bp_kind", {30'd0, flitKind}, 32'd1);
      chk("bp_valid", {31'd0, flitValid}, 32'd1);
    end
    flitReady = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Reset during DLO
    inAddr = 16'h2222; inData = 32'h33334444; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    chk("pre_rst_dlo", {16'd0, flitData}, 32'h4444);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, flitValid}, 32'd0);
    chk("async_rst_count", {24'd0, txCount}, 32'd0);
    chk("async_rst_ready", {31'd0, inReady}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_flit", {31'd0, flitValid}, 32'd0);
    end

    // Wrap: 256 transactions, ready held high
    acc = 0; iter = 0;
    inValid = 1'b1; inData = $urandom; inAddr = 16'($urandom);
    while (acc < 256 && iter < 5000) begin
      go = inValid && inReady;
      tick();
      iter++;
      if (go) begin
        acc++;
        inData = $urandom; inAddr = 16'($urandom);
      end
    end
    chk("wrap_accepted", acc, 32'd256);
    inValid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_count", {24'd0, txCount}, 32'd0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      inValid   = ($urandom_range(0, 9) < 7);
      flitReady = ($urandom_range(0, 9) < 6);
      inData    = $urandom;
      inAddr    = 16'($urandom);
      tick();
    end
    inValid = 1'b0;
    flitReady = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
